alu_bist_controller: RTL
========================

Name: alu_bist_controller

Overview:
- Built-in self-test driver and response checker for the registered ALU timing wrapper.
- Generates pseudorandom operands and sweeps opcodes into the wrapper, then compacts the wrapper's registered result and flags into a MISR signature.
- Compares the final signature with an expected value, so the ALU can be exercised on-board at the measured Fmax.

Parameters:
- WIDTH, 32: operand/result width; legal values 8, 16, 32 only.
- NUM_VECTORS, 256: vectors issued per run, 1..65535.
- SEED_A, 32'h0000_ACE1: operand-A LFSR seed, truncated to WIDTH, must be nonzero.
- SEED_B, 32'h1357_2468: operand-B LFSR seed, truncated to WIDTH, must be nonzero.
- EXP_SIGNATURE, 0: golden signature, truncated to WIDTH.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- start in 1: one-cycle pulse that begins a run.
- a out WIDTH: operand A to wrapper.
- b out WIDTH: operand B to wrapper.
- opcode out 4: ALU opcode to wrapper (unregistered inside wrapper).
- result in WIDTH: wrapper registered result.
- N in 1, Z in 1, C in 1, V in 1: wrapper registered flags.
- busy out 1: run in progress.
- done out 1: run complete, held until the next start.
- pass out 1: final signature == EXP_SIGNATURE; valid while done.
- signature out WIDTH: current MISR state.
- vec_count out 16: vectors issued this run.

Behaviour:
- Reset (sync, active-high) forces state IDLE and all outputs to 0: a, b, opcode, busy, done, pass, signature, vec_count. LFSR A is loaded with SEED_A and LFSR B with SEED_B. Capture pipe is cleared. Reset mid-run aborts immediately with no partial done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE, start=1 → RUN. On this transition: signature, vec_count, done and pass are cleared, and the LFSRs are reloaded.
  - start is ignored in RUN and DRAIN.
- Clock edges are numbered E0.. starting at the edge that samples start.
- RUN lasts exactly NUM_VECTORS cycles. Vector k (k = 0..N-1) appears on a and b after edge E(k).
  - Vector 0 is SEED_A / SEED_B; each LFSR steps once per RUN cycle.
  - LFSR step (Fibonacci): q <= {q[W-2:0], ^(q & TAP_MASK)}.
  - opcode for vector k equals k[3:0] and is driven one cycle later than a/b, i.e. after E(k+1), so it aligns with the wrapper's input registers.
  - vec_count increments at each issue and saturates at NUM_VECTORS.
- Outside RUN, a and b are driven to 0. opcode holds its aligned value for one extra cycle after RUN, then returns to 0.
- Response latency: the wrapper result for vector k is visible after E(k+2) and is sampled into the MISR at E(k+3). A 3-deep valid shift register tracks this.
- RUN → DRAIN after E(N-1) issue completes. DRAIN lasts 3 cycles, with the last capture at E(N+2). DRAIN → DONE at E(N+3).
- MISR:
  - misr_in = result ^ {0.., N, Z, C, V}, with the flags XORed into the low 4 bits.
  - sig <= {sig[W-2:0], ^(sig & TAP_MASK)} ^ misr_in, only on valid capture cycles; otherwise sig holds.
- busy is high from E0 through E(N+3), i.e. N+3 cycles.
- done and pass are registered at the DONE entry edge from the final sig.
- NUM_VECTORS=1: RUN lasts 1 cycle, the flow is otherwise identical.
- A start in the same cycle as reset loses to reset.

Optional Feature:
- ALU_BIST_ERR_INJECT_EN defined: adds input port inject_err (1 bit). When inject_err=1 on a capture edge, bit 0 of misr_in is inverted, so pass must drop.
- Undefined: no such port, and the MISR is unaffected.

Decomposition:
- Package alu_bist_pkg holds:
  - state enum bist_state_t {IDLE, RUN, DRAIN, DONE};
  - constant RESP_LATENCY = 3;
  - function tap_mask(width) returning TAP_MASK: 8 → bits 7,5,4,3; 16 → 15,14,12,3; 32 → 31,21,1,0.
- Sub-module lfsr_gen (WIDTH, SEED; en, load, q) is used for both operand LFSRs. The MISR stays inline.

Test Plan:
1. Reset values: assert reset 2 cycles, with start=1 during reset → all outputs 0, state IDLE, no run starts.
2. LFSR sequence: WIDTH=8, SEED_A=8'h01, loopback stub DUT → a sequence 01,02,04,08,11 after E0..E4; opcode 0,1,2,3 after E1..E4.
3. Run timing: NUM_VECTORS=4 → busy high for exactly 7 cycles; done=1 after E7; vec_count=4; exactly 4 MISR updates, first at E3.
4. Golden pass: reference wrapper plus a bench model of signature; set EXP_SIGNATURE to the model value → pass=1. Set EXP_SIGNATURE to the model value ^1 → pass=0.
5. Restart and abort: pulse start in DONE → signature cleared, sequence repeats identically, same signature. Assert reset at E2 of a run → outputs return to 0 and done never rises.
6. ALU_BIST_ERR_INJECT_EN: inject_err=1 at E3 only, with golden EXP_SIGNATURE → pass=0; final signature differs from golden.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared types and helpers for the ALU BIST controller:
// FSM state enum, response latency and LFSR/MISR tap masks.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } bist_state_t;

  localparam int RESP_LATENCY = 3;

  function automatic logic [31:0] tap_mask(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_D008;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/alu_bist_controller_lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR operand generator.
// Ports: clk, en (step), load (reload SEED, wins over en), q (state).
module lfsr_gen
  import alu_bist_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             en,
  input  logic             load,
  output logic [WIDTH-1:0] q
);

  localparam logic [31:0] TAP32 = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAP = TAP32[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (load) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= {r_q[WIDTH-2:0], ^(r_q & TAP)};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/alu_bist_controller.sv
// alu_bist_controller: drives LFSR operands and an opcode sweep into the
// registered ALU wrapper, compacts result+flags into a MISR, checks it.
// Ports: clk, reset (sync, high), start; a/b/opcode to wrapper;
// result/N/Z/C/V from wrapper; busy, done, pass, signature, vec_count.
// Optional: ALU_BIST_ERR_INJECT_EN adds inject_err (flips misr_in[0]).
module alu_bist_controller
  import alu_bist_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter int          NUM_VECTORS   = 256,
  parameter logic [31:0] SEED_A        = 32'h0000_ACE1,
  parameter logic [31:0] SEED_B        = 32'h1357_2468,
  parameter logic [31:0] EXP_SIGNATURE = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef ALU_BIST_ERR_INJECT_EN
  input  logic             inject_err,
`endif
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       opcode,
  input  logic [WIDTH-1:0] result,
  input  logic             N,
  input  logic             Z,
  input  logic             C,
  input  logic             V,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      vec_count
);

  localparam logic [WIDTH-1:0] SA = SEED_A[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SB = SEED_B[WIDTH-1:0];
  localparam logic [WIDTH-1:0] EXP = EXP_SIGNATURE[WIDTH-1:0];
  localparam logic [31:0] TAP32 = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAP = TAP32[WIDTH-1:0];
  localparam logic [15:0] NV = 16'(NUM_VECTORS);
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

  bist_state_t r_state;
  bist_state_t w_next;

  logic [RESP_LATENCY-1:0] r_vld;
  logic [3:0]       r_opcode;
  logic [WIDTH-1:0] r_sig;
  logic [15:0]      r_cnt;
  logic             r_done;
  logic             r_pass;

  logic             w_start_run;
  logic             w_load;
  logic             w_run;
  logic             w_inj;
  logic [WIDTH-1:0] w_qa;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_misr_in;
  logic [WIDTH-1:0] w_sig_next;

`ifdef ALU_BIST_ERR_INJECT_EN
  assign w_inj = inject_err;
`else
  assign w_inj = 1'b0;
`endif

  assign w_run = (r_state == RUN);
  assign w_start_run = start &&
    ((r_state == IDLE) || (r_state == DONE));
  assign w_load = reset || w_start_run;

  lfsr_gen #(.WIDTH(WIDTH), .SEED(SA)) u_lfsr_a (
    .clk  (clk),
    .en   (w_run),
    .load (w_load),
    .q    (w_qa)
  );

  lfsr_gen #(.WIDTH(WIDTH), .SEED(SB)) u_lfsr_b (
    .clk  (clk),
    .en   (w_run),
    .load (w_load),
    .q    (w_qb)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_next = RUN;
      RUN:        if (r_cnt == LAST) w_next = DRAIN;
      // DRAIN ends once the last in-flight vector is captured
      DRAIN:      if (r_vld == '0) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  assign w_misr_in = result
    ^ {{(WIDTH-4){1'b0}}, N, Z, C, V}
    ^ {{(WIDTH-1){1'b0}}, w_inj};
  assign w_sig_next = {r_sig[WIDTH-2:0], ^(r_sig & TAP)}
    ^ w_misr_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_vld    <= '0;
      r_opcode <= 4'h0;
      r_sig    <= '0;
      r_cnt    <= 16'h0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state <= w_next;
      // opcode trails a/b by one cycle to meet the wrapper input regs
      r_opcode <= w_run ? r_cnt[3:0] : 4'h0;
      // a vector is issued on every edge that leaves state RUN active
      r_vld <= {r_vld[RESP_LATENCY-2:0], (w_next == RUN)};
      if (w_start_run) begin
        r_sig  <= '0;
        r_cnt  <= 16'h0;
        r_done <= 1'b0;
        r_pass <= 1'b0;
      end else begin
        if (w_run && (r_cnt != NV)) begin
          r_cnt <= r_cnt + 16'h1;
        end
        if (r_vld[RESP_LATENCY-1]) begin
          r_sig <= w_sig_next;
        end
        if ((r_state == DRAIN) && (w_next == DONE)) begin
          r_done <= 1'b1;
          r_pass <= (r_sig == EXP);
        end
      end
    end
  end

  assign a         = w_run ? w_qa : '0;
  assign b         = w_run ? w_qb : '0;
  assign opcode    = r_opcode;
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;
  assign vec_count = r_cnt;

endmodule
